// File: rtl/partial_product_seq.sv
// partial_product_seq
//   Sequential 2-limb x 2-limb unsigned multiplier. An accepted operand pair
//   is split into LIMB_W-bit limbs and four limb products are streamed out
//   one per beat on the pp_* channel. Each accepted beat is also shifted to
//   its weight and added into an internal accumulator. Once all four beats
//   have been accepted, the full product is offered on the res_* channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block idle, can take an operand pair
//   a, b       2*LIMB_W-bit unsigned operands
//   pp_valid   partial-product beat valid
//   pp_ready   downstream accepts the beat
//   pp_data    limb product, 2*LIMB_W bits
//   pp_shift   weight of pp_data in LIMB_W units (0, 1 or 2)
//   pp_last    set on the fourth beat
//   res_valid  full product valid
//   res_ready  downstream accepts the product
//   res        4*LIMB_W-bit product a*b
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair, in_ready=1
// EMIT  | streaming beat k (0..3) of the latched operands, pp_valid=1
// DONE  | full product on res, res_valid=1, waiting for res_ready
module partial_product_seq #(
  parameter int LIMB_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LIMB_W-1:0]   a,
  input  logic [2*LIMB_W-1:0]   b,
  output logic                  pp_valid,
  input  logic                  pp_ready,
  output logic [2*LIMB_W-1:0]   pp_data,
  output logic [1:0]            pp_shift,
  output logic                  pp_last,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [4*LIMB_W-1:0]   res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            r_k;
  logic [2*LIMB_W-1:0]   r_a;
  logic [2*LIMB_W-1:0]   r_b;
  logic [4*LIMB_W-1:0]   r_acc;

  logic [LIMB_W-1:0]     w_x;
  logic [LIMB_W-1:0]     w_y;
  logic [2*LIMB_W-1:0]   w_prod;
  logic [4*LIMB_W-1:0]   w_pp_ext;
  logic [4*LIMB_W-1:0]   w_pp_wtd;

  // Beat order aL*bL, aH*bL, aL*bH, aH*bH: k[0] picks the a limb and k[1]
  // picks the b limb, so one multiplier serves all four beats.
  assign w_x    = r_k[0] ? r_a[2*LIMB_W-1:LIMB_W] : r_a[LIMB_W-1:0];
  assign w_y    = r_k[1] ? r_b[2*LIMB_W-1:LIMB_W] : r_b[LIMB_W-1:0];
  assign w_prod = {{LIMB_W{1'b0}}, w_x} * {{LIMB_W{1'b0}}, w_y};

  // Weight is the number of high limbs involved: 0, 1, 1, 2.
  assign pp_shift = {r_k[1] & r_k[0], r_k[1] ^ r_k[0]};
  assign pp_data  = w_prod;

  assign w_pp_ext = {{(2*LIMB_W){1'b0}}, w_prod};

  always_comb begin
    w_pp_wtd = w_pp_ext;
    case (pp_shift)
      2'd1:    w_pp_wtd = w_pp_ext << LIMB_W;
      2'd2:    w_pp_wtd = w_pp_ext << (2*LIMB_W);
      default: w_pp_wtd = w_pp_ext;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign pp_valid  = (r_state == S_EMIT);
  assign pp_last   = (r_state == S_EMIT) && (r_k == 2'd3);
  assign res_valid = (r_state == S_DONE);
  assign res       = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_k     <= 2'd0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (pp_ready) begin
            // Sum of the four weighted limb products is exactly a*b, which
            // fits in 4*LIMB_W bits, so the add never wraps.
            r_acc <= r_acc + w_pp_wtd;
            r_k   <= r_k + 2'd1;
            if (r_k == 2'd3) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // res keeps r_acc after the handshake; only a new accept clears it.
          if (res_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_partial_product_seq.sv
module tb_partial_product_seq;

  localparam int W = 12;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] a;
  logic [2*W-1:0] b;
  logic          pp_valid;
  logic          pp_ready;
  logic [2*W-1:0] pp_data;
  logic [1:0]    pp_shift;
  logic          pp_last;
  logic          res_valid;
  logic          res_ready;
  logic [4*W-1:0] res;

  partial_product_seq #(.LIMB_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data),
    .pp_shift(pp_shift), .pp_last(pp_last),
    .res_valid(res_valid), .res_ready(res_ready), .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [2*W-1:0] d;
    logic [1:0]     s;
    logic           l;
  } beat_t;

  beat_t          bq[$];
  logic [4*W-1:0] rq[$];
  int             n_acc  = 0;
  int             n_done = 0;

  // Expected beats from plain limb arithmetic; expected result is simply a*b.
  task automatic model_push(input logic [2*W-1:0] oa, input logic [2*W-1:0] ob);
    logic [63:0] base, al, ah, bl, bh, prod;
    base = 64'd1 << W;
    al = 64'(oa) % base;  ah = 64'(oa) / base;
    bl = 64'(ob) % base;  bh = 64'(ob) / base;
    prod = 64'(oa) * 64'(ob);
    bq.push_back('{d: (2*W)'(al * bl), s: 2'd0, l: 1'b0});
    bq.push_back('{d: (2*W)'(ah * bl), s: 2'd1, l: 1'b0});
    bq.push_back('{d: (2*W)'(al * bh), s: 2'd1, l: 1'b0});
    bq.push_back('{d: (2*W)'(ah * bh), s: 2'd2, l: 1'b1});
    rq.push_back((4*W)'(prod));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bq.delete();
      rq.delete();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_pp_valid", 64'(pp_valid), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
    end else begin
      chk("mon_in_ready", 64'(in_ready), 64'(!(pp_valid || res_valid)));
      if (pp_valid) begin
        if (bq.size() == 0) begin
          chk("mon_pp_spurious", 64'(pp_valid), 64'd0);
        end else begin
          chk("mon_pp_data", 64'(pp_data), 64'(bq[0].d));
          chk("mon_pp_shift", 64'(pp_shift), 64'(bq[0].s));
          chk("mon_pp_last", 64'(pp_last), 64'(bq[0].l));
          if (pp_ready) void'(bq.pop_front());
        end
      end else begin
        chk("mon_pp_last_idle", 64'(pp_last), 64'd0);
      end
      if (res_valid) begin
        if (rq.size() == 0 || bq.size() != 0) begin
          chk("mon_res_spurious", 64'(res_valid), 64'd0);
        end else begin
          chk("mon_res", 64'(res), 64'(rq[0]));
          if (res_ready) begin
            void'(rq.pop_front());
            n_done++;
          end
        end
      end
      if (in_valid && in_ready) begin
        model_push(a, b);
        n_acc++;
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2*W-1:0]      a;
    logic [2*W-1:0]      b;
    logic [3:0][2*W-1:0] d;   // d[k] = expected beat k
    logic [4*W-1:0]      r;
  } vec_t;

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    pp_ready  = 1'b1;
    res_ready = 1'b1;
    while (!in_ready && n < 200) begin
      cycle();
      n++;
    end
    chk("wait_idle", 64'(in_ready), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] sh;
    wait_idle();
    a = v.a; b = v.b; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sh = (k == 0) ? 2'd0 : (k == 3) ? 2'd2 : 2'd1;
      chk({tag, "_pp_valid"}, 64'(pp_valid), 64'd1);
      chk({tag, "_pp_data"}, 64'(pp_data), 64'(v.d[k]));
      chk({tag, "_pp_shift"}, 64'(pp_shift), 64'(sh));
      chk({tag, "_pp_last"}, 64'(pp_last), 64'(k == 3));
      cycle();
    end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_res"}, 64'(res), 64'(v.r));
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    cycle();
    chk({tag, "_ready_n6"}, 64'(in_ready), 64'd1);
    chk({tag, "_res_drop"}, 64'(res_valid), 64'd0);
    chk({tag, "_res_hold"}, 64'(res), 64'(v.r));
  endtask

  vec_t vecs[7];

  initial begin
    int base_acc, base_done, cyc;
    logic [4*W-1:0] exp_r;

    vecs[0] = '{24'h123456, 24'h000002, {24'h0, 24'h0, 24'h000246, 24'h0008AC}, 48'h0000002468AC};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, {24'hFFE001, 24'hFFE001, 24'hFFE001, 24'hFFE001}, 48'hFFFFFE000001};
    vecs[2] = '{24'h000003, 24'h000005, {24'h0, 24'h0, 24'h0, 24'h00000F}, 48'h00000000000F};
    vecs[3] = '{24'h000001, 24'h000001, {24'h0, 24'h0, 24'h0, 24'h000001}, 48'h000000000001};
    vecs[4] = '{24'h000FFF, 24'hFFF000, {24'h0, 24'hFFE001, 24'h0, 24'h0}, 48'h000FFE001000};
    vecs[5] = '{24'hFFF000, 24'h000FFF, {24'h0, 24'h0, 24'hFFE001, 24'h0}, 48'h000FFE001000};
    vecs[6] = '{24'h000000, 24'hFFFFFF, {24'h0, 24'h0, 24'h0, 24'h0}, 48'h000000000000};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; pp_ready = 1'b1; res_ready = 1'b1;
    repeat (3) cycle();
    chk("reset_pp_data", 64'(pp_data), 64'd0);
    chk("reset_pp_shift", 64'(pp_shift), 64'd0);
    chk("reset_pp_last", 64'(pp_last), 64'd0);
    chk("reset_res", 64'(res), 64'd0);
    rst_n = 1'b1;

    // first vector is accepted on the first edge after release
    for (int i = 0; i < 7; i++) run_vec(vecs[i], "vec");

    // pp_ready stall at k=1
    wait_idle();
    a = 24'h000001; b = 24'h000001; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("stall_k0_data", 64'(pp_data), 64'd1);
    cycle();
    pp_ready = 1'b0;
    repeat (3) begin
      chk("stall_valid", 64'(pp_valid), 64'd1);
      chk("stall_data", 64'(pp_data), 64'd0);
      chk("stall_shift", 64'(pp_shift), 64'd1);
      cycle();
    end
    chk("stall_still_k1", 64'(pp_shift), 64'd1);
    pp_ready = 1'b1;
    cycle();
    chk("stall_k2_last", 64'(pp_last), 64'd0);
    cycle();
    chk("stall_k3_last", 64'(pp_last), 64'd1);
    chk("stall_k3_shift", 64'(pp_shift), 64'd2);
    cycle();
    chk("stall_res_valid", 64'(res_valid), 64'd1);
    chk("stall_res", 64'(res), 64'd1);

    // res_ready stall with in_valid held high
    wait_idle();
    res_ready = 1'b0;
    a = 24'h00ABCD; b = 24'h001234; in_valid = 1'b1;
    exp_r = 48'h00ABCD * 48'h001234;
    cycle();
    a = 24'h000003; b = 24'h000007;
    repeat (4) cycle();
    repeat (5) begin
      chk("rstall_valid", 64'(res_valid), 64'd1);
      chk("rstall_res", 64'(res), 64'(exp_r));
      chk("rstall_in_ready", 64'(in_ready), 64'd0);
      cycle();
    end
    res_ready = 1'b1;
    cycle();
    chk("rstall_idle", 64'(in_ready), 64'd1);
    chk("rstall_res_hold", 64'(res), 64'(exp_r));
    cycle();
    in_valid = 1'b0;
    chk("rstall_next_valid", 64'(pp_valid), 64'd1);
    chk("rstall_next_data", 64'(pp_data), 64'd21);

    // reset during beat k=2
    wait_idle();
    a = 24'h123456; b = 24'h654321; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle(); cycle();
    chk("mid_k2_shift", 64'(pp_shift), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pp_valid", 64'(pp_valid), 64'd0);
    chk("mid_rst_pp_last", 64'(pp_last), 64'd0);
    chk("mid_rst_pp_data", 64'(pp_data), 64'd0);
    chk("mid_rst_pp_shift", 64'(pp_shift), 64'd0);
    chk("mid_rst_res_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_res", 64'(res), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    cycle();
    rst_n = 1'b1;
    run_vec(vecs[2], "post_rst");

    // randomized back-to-back traffic
    wait_idle();
    base_acc  = n_acc;
    base_done = n_done;
    cyc = 0;
    while ((n_acc - base_acc) < 1000 && cyc < 40000) begin
      in_valid = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 3))
        0: a = 24'hFFFFFF;
        1: a = 24'(($urandom_range(0, 1) == 0) ? $urandom_range(0, 4095) : ($urandom_range(0, 4095) << 12));
        default: a = 24'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = 24'hFFFFFF;
        1: b = 24'($urandom_range(0, 15));
        default: b = 24'($urandom);
      endcase
      pp_ready  = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    in_valid = 1'b0;
    pp_ready = 1'b1;
    res_ready = 1'b1;
    repeat (20) cycle();
    chk("rand_enough_ops", 64'((n_acc - base_acc) >= 1000), 64'd1);
    chk("rand_all_done", 64'(n_done - base_done), 64'(n_acc - base_acc));
    chk("rand_drained", 64'(bq.size() + rq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
